// File: rtl/fdiv_ratio_ctrl.sv
// Ratio/reset controller for the integer clock divider: arbitrates two requesters
// and applies a new ratio only at a div_clk falling edge. Optional macro: FDIV_CTRL_TIMEOUT_EN.
`timescale 1ns/1ps
module fdiv_ratio_ctrl #(
    parameter logic [7:0] N_DEFAULT = 8'd2,
    parameter logic [7:0] MIN_N     = 8'd2,
    parameter int         RST_LEN   = 2,
    parameter int         TIMEOUT   = 512
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       req0_vld,
    input  logic [7:0] req0_n,
    output logic       req0_rdy,
    input  logic       req1_vld,
    input  logic [7:0] req1_n,
    output logic       req1_rdy,
    input  logic       div_clk,
    output logic [7:0] div_n,
    output logic       div_rst_n,
    output logic       busy,
    output logic       grant_id,
    output logic       timeout_err
);
    typedef enum logic [1:0] {IDLE, WAIT_EDGE, APPLY, SETTLE} state_t;

    state_t     state, state_nx;
    logic [7:0] pending;
    logic [7:0] acc_n;
    logic [7:0] acc_clamped;
    logic [3:0] hold_cnt;
    logic       div_q;
    logic       fall;
    logic       win0, win1;
    logic       acc;
    logic       forced;
    logic       fire;

    assign fall = div_q & ~div_clk;

    // On contention the requester that did not win last time gets the grant.
    assign win0 = req0_vld & (~req1_vld | grant_id);
    assign win1 = req1_vld & (~req0_vld | ~grant_id);
    assign req0_rdy = (state == IDLE) & ~rst & win0;
    assign req1_rdy = (state == IDLE) & ~rst & win1;
    assign acc = req0_rdy | req1_rdy;
    assign acc_n = req1_rdy ? req1_n : req0_n;
    assign acc_clamped = (acc_n < MIN_N) ? MIN_N : acc_n;
    assign busy = (state != IDLE);

`ifdef FDIV_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    logic [TW-1:0] to_cnt;

    assign forced = (to_cnt == TW'(TIMEOUT - 1));

    // Counter sits at zero outside WAIT_EDGE, so every wait starts from a clean count.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst)
            to_cnt <= '0;
        else if (state != WAIT_EDGE)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 1'b1;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst)
            timeout_err <= 1'b0;
        else if (state == WAIT_EDGE && fire)
            timeout_err <= ~fall;
    end
`else
    assign forced = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign fire = fall | forced;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (acc && acc_clamped != div_n) state_nx = WAIT_EDGE;
            WAIT_EDGE: if (fire) state_nx = APPLY;
            APPLY:     if (hold_cnt == 4'(RST_LEN - 1)) state_nx = SETTLE;
            SETTLE:    state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            div_q     <= 1'b0;
            pending   <= N_DEFAULT;
            grant_id  <= 1'b1;
            div_n     <= N_DEFAULT;
            div_rst_n <= 1'b0;
            hold_cnt  <= 4'd0;
        end else begin
            state     <= state_nx;
            div_q     <= div_clk;
            div_rst_n <= (state_nx != APPLY);
            hold_cnt  <= (state == APPLY) ? hold_cnt + 4'd1 : 4'd0;
            if (acc) begin
                pending  <= acc_clamped;
                grant_id <= req1_rdy;
            end
            // div_n only moves on the WAIT_EDGE -> APPLY transition.
            if (state == WAIT_EDGE && fire)
                div_n <= pending;
        end
    end
endmodule

// File: tb/tb_fdiv_ratio_ctrl.sv
// Bench for fdiv_ratio_ctrl: transaction-level model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_fdiv_ratio_ctrl;
    localparam logic [7:0] N_DEFAULT = 8'd2;
    localparam logic [7:0] MIN_N     = 8'd2;
    localparam int         RST_LEN   = 2;
    localparam int         TIMEOUT   = 512;
`ifdef FDIV_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       req0_vld = 1'b0, req1_vld = 1'b0;
    logic [7:0] req0_n = 8'd0, req1_n = 8'd0;
    logic       req0_rdy, req1_rdy;
    logic       div_clk = 1'b0;
    logic [7:0] div_n;
    logic       div_rst_n, busy, grant_id, timeout_err;

    fdiv_ratio_ctrl #(.N_DEFAULT(N_DEFAULT), .MIN_N(MIN_N), .RST_LEN(RST_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk_in(clk_in), .rst(rst),
        .req0_vld(req0_vld), .req0_n(req0_n), .req0_rdy(req0_rdy),
        .req1_vld(req1_vld), .req1_n(req1_n), .req1_rdy(req1_rdy),
        .div_clk(div_clk), .div_n(div_n), .div_rst_n(div_rst_n),
        .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
    );

    always #5 clk_in = ~clk_in;

    int vectors = 0, errors = 0, cyc = 0;

    // Model: a change is either waiting for an edge, or counting down the
    // remaining reset+settle cycles (post); idle when neither.
    logic [7:0] m_div_n, m_pend;
    bit  m_rstn, m_grant, m_terr, m_divq, m_wait;
    int  m_post, m_cnt;

    bit  acc0, acc1;
    int  acc_cyc0, rdy0_hi;
    bit  gq[$];

    int  dmode = 1, dcnt = 0;
    bit  rnd_req = 0, prev_d = 0, fell;
    int  e_cyc, drop_cyc, rst_low, busy_cnt, g_base, r0_base;
    bit  saw_busy;
    logic [7:0] n_at_drop;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_div_n = N_DEFAULT; m_pend = N_DEFAULT; m_rstn = 0; m_grant = 1;
        m_terr = 0; m_divq = 0; m_wait = 0; m_post = 0; m_cnt = 0;
    endtask

    task automatic compare_step();
        bit idle, e0, e1, mf;
        logic [7:0] p;
        if (rst) model_reset();
        idle = !m_wait && m_post == 0;
        e0 = !rst && idle && req0_vld && (!req1_vld || m_grant);
        e1 = !rst && idle && req1_vld && (!req0_vld || !m_grant);
        chk("req0_rdy", req0_rdy, e0);
        chk("req1_rdy", req1_rdy, e1);
        chk("div_n", div_n, m_div_n);
        chk("div_rst_n", div_rst_n, m_rstn);
        chk("busy", busy, !idle);
        chk("grant_id", grant_id, m_grant);
        chk("timeout_err", timeout_err, m_terr);
        if (req0_rdy === 1'b1) rdy0_hi++;
        if (!rst) begin
            mf = m_divq && !div_clk;
            m_divq = div_clk;
            if (m_post > 0) begin
                m_post--;
            end else if (m_wait) begin
                if (mf || (TO_EN && m_cnt == TIMEOUT - 1)) begin
                    m_div_n = m_pend;
                    m_post = RST_LEN + 1;
                    m_wait = 0;
                    m_terr = TO_EN && !mf;
                end else begin
                    m_cnt++;
                end
            end else if (e0 || e1) begin
                p = e1 ? req1_n : req0_n;
                if (p < MIN_N) p = MIN_N;
                m_grant = e1;
                m_pend = p;
                gq.push_back(e1);
                if (e1) acc1 = 1;
                else begin acc0 = 1; acc_cyc0 = cyc; end
                if (p != m_div_n) begin m_wait = 1; m_cnt = 0; end
            end
            m_rstn = (m_post <= 1);
        end
    endtask

    function automatic logic [7:0] rand_n();
        case ($urandom_range(3))
            0: return 8'($urandom_range(3));
            1: return m_div_n;
            default: return 8'($urandom_range(255));
        endcase
    endfunction

    task automatic clr_trk();
        e_cyc = -1; drop_cyc = -1; rst_low = 0; busy_cnt = 0; saw_busy = 0;
        r0_base = rdy0_hi; g_base = gq.size();
    endtask

    // Compare at the falling edge, then let the rising edge happen and set
    // up the next cycle's inputs one step after it.
    task automatic tick();
        @(negedge clk_in);
        compare_step();
        @(posedge clk_in);
        #1;
        cyc++;
        if (acc0) begin acc0 = 0; req0_vld = 0; end
        if (acc1) begin acc1 = 0; req1_vld = 0; end
        if (rnd_req) begin
            if (!req0_vld && $urandom_range(3) == 0) begin req0_vld = 1; req0_n = rand_n(); end
            if (!req1_vld && $urandom_range(3) == 0) begin req1_vld = 1; req1_n = rand_n(); end
        end
        prev_d = div_clk;
        case (dmode)
            0: div_clk = 1'b0;
            1: begin
                dcnt++;
                if (dcnt == 3) begin dcnt = 0; div_clk = ~div_clk; end
            end
            default: if ($urandom_range(2) == 0) div_clk = ~div_clk;
        endcase
        fell = prev_d && !div_clk;
        if (!div_rst_n) rst_low++;
        if (busy) begin
            busy_cnt++;
            saw_busy = 1;
            if (fell && e_cyc < 0) e_cyc = cyc;
        end else if (saw_busy && drop_cyc < 0) begin
            drop_cyc = cyc;
            n_at_drop = div_n;
        end
    endtask

    task automatic wait_idle(int limit, string name);
        int i = 0;
        do begin tick(); i++; end while ((req0_vld || req1_vld || busy) && i < limit);
        if (req0_vld || req1_vld || busy) begin
            vectors++; errors++;
            $display("FAIL %s: not idle after %0d cycles", name, limit);
        end
    endtask

    initial begin
        model_reset();
        // Reset: present a request, which must not be taken while rst is high.
        req0_vld = 1; req0_n = 8'd6;
        repeat (3) tick();
        chk("rst div_n", div_n, 2);
        chk("rst div_rst_n", div_rst_n, 0);
        chk("rst busy", busy, 0);
        chk("rst grant_id", grant_id, 1);
        chk("rst timeout_err", timeout_err, 0);
        chk("rst req0_rdy", req0_rdy, 0);
        clr_trk();
        rst = 0;
        chk("release div_rst_n low", div_rst_n, 0);
        tick();
        chk("release div_rst_n high", div_rst_n, 1);

        // req0 n=6 with div_clk toggling.
        wait_idle(100, "req0 n=6");
        chk("n6 rdy0 cycles", rdy0_hi - r0_base, 1);
        chk("n6 div_n", div_n, 6);
        chk("n6 rst low cycles", rst_low, 2);
        chk("n6 busy drop after edge", drop_cyc - e_cyc, 4);
        chk("n6 grant_id", grant_id, 0);

        // Both valid after a grant to 0: req1 first, then req0 right after.
        clr_trk();
        req0_vld = 1; req0_n = 8'd11;
        req1_vld = 1; req1_n = 8'd5;
        wait_idle(200, "contention");
        chk("rr grants", gq.size() - g_base, 2);
        chk("rr first id", gq[g_base], 1);
        chk("rr second id", gq[g_base + 1], 0);
        chk("rr first div_n", n_at_drop, 5);
        chk("rr req0 accepted at first idle", acc_cyc0, drop_cyc);
        chk("rr final div_n", div_n, 11);

        // Clamp of n=0, then a no-op request equal to the current ratio.
        req1_vld = 1; req1_n = 8'd0;
        wait_idle(100, "clamp");
        chk("clamp div_n", div_n, 2);
        clr_trk();
        req1_vld = 1; req1_n = 8'd2;
        repeat (10) tick();
        chk("noop accepted", req1_vld, 0);
        chk("noop busy cycles", busy_cnt, 0);
        chk("noop rst low cycles", rst_low, 0);
        chk("noop grant_id", grant_id, 1);

        // Stalled divider.
        dmode = 0;
        repeat (3) tick();
        clr_trk();
        req0_vld = 1; req0_n = 8'd9;
`ifdef FDIV_CTRL_TIMEOUT_EN
        wait_idle(700, "timeout");
        chk("timeout div_n", div_n, 9);
        chk("timeout err", timeout_err, 1);
        chk("timeout busy cycles", busy_cnt, 515);
        dmode = 1;
        req1_vld = 1; req1_n = 8'd4;
        wait_idle(100, "after timeout");
        chk("err cleared", timeout_err, 0);
        chk("after timeout div_n", div_n, 4);
`else
        repeat (600) tick();
        chk("stall busy", busy, 1);
        chk("stall div_n", div_n, 2);
        chk("stall err", timeout_err, 0);
        dmode = 1;
        wait_idle(100, "stall release");
        chk("stall release div_n", div_n, 9);
`endif

        // Reset in the middle of WAIT_EDGE.
        dmode = 0;
        repeat (3) tick();
        req0_vld = 1; req0_n = 8'd11;
        repeat (5) tick();
        chk("pre-rst busy", busy, 1);
        #2;
        rst = 1;
        req0_vld = 1; req0_n = 8'd11;
        #1;
        chk("async rst div_n", div_n, 2);
        chk("async rst div_rst_n", div_rst_n, 0);
        chk("async rst busy", busy, 0);
        chk("async rst grant_id", grant_id, 1);
        chk("async rst timeout_err", timeout_err, 0);
        chk("async rst req0_rdy", req0_rdy, 0);
        repeat (2) tick();
        rst = 0;
        dmode = 1;
        wait_idle(100, "re-present");
        chk("re-present div_n", div_n, 11);

        // Randomized traffic with a jittery div_clk.
        dmode = 2;
        rnd_req = 1;
        repeat (2000) tick();
        rnd_req = 0;
        wait_idle(2000, "random drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
